// File: rtl/spi_slave.sv
// SPI mode-0 responder: resynchronises sclk/ss/mosi into clk, deserialises MOSI words and shifts a buffered word out on MISO (MSB first).
// Pin-to-action latency is 3 clk edges; a one-word transmit buffer holds tx_ready low while it is full.
module spi_slave #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic             sclk_s1, sclk_s2, sclk_s3;
  logic             ss_s1, ss_s2, ss_s3;
  logic             mosi_s1, mosi_s2;
  logic [WIDTH-1:0] tx_buf;
  logic             full;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [CW-1:0]    bit_cnt;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic shifting, load_pt, last_bit;

  always_comb begin
    sclk_rise = sclk_s2 & ~sclk_s3;
    sclk_fall = ~sclk_s2 & sclk_s3;
    ss_rise   = ss_s2 & ~ss_s3;
    ss_fall   = ~ss_s2 & ss_s3;
    // ss release outranks any sclk edge seen in the same cycle
    shifting  = (state == ST_SHIFT) && !ss_rise;
    last_bit  = (bit_cnt == CW'(WIDTH - 1));
    load_pt   = ((state == ST_IDLE) && ss_fall) ||
                (shifting && sclk_fall && (bit_cnt == '0));
  end

  assign miso     = (state == ST_SHIFT) ? tx_shift[WIDTH-1] : 1'b0;
  assign busy     = (state == ST_SHIFT);
  assign tx_ready = ~full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      sclk_s1     <= 1'b0;
      sclk_s2     <= 1'b0;
      sclk_s3     <= 1'b0;
      ss_s1       <= 1'b1;
      ss_s2       <= 1'b1;
      ss_s3       <= 1'b1;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      tx_buf      <= '0;
      full        <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sclk_s1     <= sclk;
      sclk_s2     <= sclk_s1;
      sclk_s3     <= sclk_s2;
      ss_s1       <= ss;
      ss_s2       <= ss_s1;
      ss_s3       <= ss_s2;
      mosi_s1     <= mosi;
      mosi_s2     <= mosi_s1;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // A write only lands while empty, so a load in the same cycle sees empty and sends FILL
      if (tx_valid && !full) begin
        tx_buf <= tx_data;
        full   <= 1'b1;
      end

      if (load_pt) begin
        if (full) begin
          tx_shift <= tx_buf;
          full     <= 1'b0;
        end else begin
          tx_shift    <= FILL;
          tx_underrun <= 1'b1;
        end
      end else if (shifting && sclk_fall) begin
        tx_shift <= tx_shift << 1;
      end

      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        default: begin
          if (ss_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_s2};
            if (last_bit) begin
              rx_data  <= {rx_shift[WIDTH-2:0], mosi_s2};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives the pins and checks MISO, RX words and pulses.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int rv_cnt = 0, uf_cnt = 0, rv_cyc = 0, uf_cyc = 0;
  logic [7:0] rv_last = 8'h00, rv_prev = 8'h00;
  int rise_cyc, ss_fall_cyc;
  logic busy_e2, busy_e3;
  logic [15:0] got;
  int rv0, uf0;

  spi_slave #(.WIDTH(8), .FILL(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      rv_cnt  <= rv_cnt + 1;
      rv_prev <= rv_last;
      rv_last <= rx_data;
      rv_cyc  <= cyc;
    end
    if (tx_underrun) begin
      uf_cnt <= uf_cnt + 1;
      uf_cyc <= cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    int k;
    k = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("tx_write_timeout", 32'd1, 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master frame of nbits bits; the final sclk fall coincides with ss release.
  task automatic spi_frame(input int nbits, input logic [15:0] mo, input logic col,
                           input logic [7:0] col_dat, output logic [15:0] mi);
    mi = '0;
    @(negedge clk);
    ss = 1'b0;
    mosi = mo[nbits-1];
    ss_fall_cyc = cyc;
    if (col) begin
      repeat (2) @(negedge clk);
      tx_data  = col_dat;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    for (int b = 0; b < nbits; b++) begin
      mi = {mi[14:0], miso};
      sclk = 1'b1;
      rise_cyc = cyc;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      if (b == nbits - 1) begin
        ss = 1'b1;
        repeat (2) @(negedge clk);
        busy_e2 = busy;
        @(negedge clk);
        busy_e3 = busy;
      end else begin
        mosi = mo[nbits-2-b];
        repeat (5) @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    // Reset with pins and tx_valid toggling
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_outputs", {27'd0, miso, busy, tx_ready, rx_valid, tx_underrun}, 32'b00100);
      check("rst_rx_data", {24'd0, rx_data}, 32'h00);
      sclk = ~sclk;
      ss   = ~ss;
      mosi = ~mosi;
    end
    sclk = 1'b0; ss = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_outputs", {27'd0, miso, busy, tx_ready, rx_valid, tx_underrun}, 32'b00100);
    check("post_rst_pulses", rv_cnt + uf_cnt, 0);

    // Single word
    write_tx(8'hA5);
    check("single_tx_ready_full", {31'd0, tx_ready}, 0);
    rv0 = rv_cnt; uf0 = uf_cnt;
    spi_frame(8, 16'h003C, 1'b0, 8'h00, got);
    check("single_miso", {24'd0, got[7:0]}, 32'hA5);
    check("single_rx_data", {24'd0, rx_data}, 32'h3C);
    check("single_rv_count", rv_cnt - rv0, 1);
    check("single_rv_latency", rv_cyc - rise_cyc, 3);
    check("single_no_underrun", uf_cnt - uf0, 0);
    check("single_tx_ready", {31'd0, tx_ready}, 1);
    check("single_busy_idle", {31'd0, busy}, 0);

    // Back-to-back words with ss held low
    write_tx(8'h11);
    rv0 = rv_cnt; uf0 = uf_cnt;
    fork
      spi_frame(16, 16'h0102, 1'b0, 8'h00, got);
      write_tx(8'h22);
    join
    check("b2b_miso", {16'd0, got}, 32'h1122);
    check("b2b_rv_count", rv_cnt - rv0, 2);
    check("b2b_first_word", {24'd0, rv_prev}, 32'h01);
    check("b2b_second_word", {24'd0, rv_last}, 32'h02);
    check("b2b_no_underrun", uf_cnt - uf0, 0);

    // Underrun
    rv0 = rv_cnt; uf0 = uf_cnt;
    spi_frame(8, 16'h00FF, 1'b0, 8'h00, got);
    check("uf_miso_fill", {24'd0, got[7:0]}, 32'h00);
    check("uf_count", uf_cnt - uf0, 1);
    check("uf_latency", uf_cyc - ss_fall_cyc, 3);
    check("uf_rx_data", {24'd0, rx_data}, 32'hFF);

    // Abort after 5 bits of 8'hC3, then a full word
    rv0 = rv_cnt;
    spi_frame(5, 16'h0018, 1'b0, 8'h00, got);
    check("abort_no_rv", rv_cnt - rv0, 0);
    check("abort_busy_e2", {31'd0, busy_e2}, 1);
    check("abort_busy_e3", {31'd0, busy_e3}, 0);
    check("abort_rx_held", {24'd0, rx_data}, 32'hFF);
    write_tx(8'h96);
    rv0 = rv_cnt;
    spi_frame(8, 16'h005A, 1'b0, 8'h00, got);
    check("after_abort_rx", {24'd0, rx_data}, 32'h5A);
    check("after_abort_rv", rv_cnt - rv0, 1);
    check("after_abort_miso", {24'd0, got[7:0]}, 32'h96);

    // Write lands in the very cycle of the first load point
    rv0 = rv_cnt; uf0 = uf_cnt;
    spi_frame(16, 16'h1234, 1'b1, 8'h7E, got);
    check("col_miso", {16'd0, got}, 32'h007E);
    check("col_underrun", uf_cnt - uf0, 1);
    check("col_words", {16'd0, rv_prev, rv_last}, 32'h1234);
    check("col_rv_count", rv_cnt - rv0, 2);
    check("col_tx_ready", {31'd0, tx_ready}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the far end of the processor's SPI master link (sclk, ss, mosi, miso). It oversamples the master's serial lines in the local clk domain, deserialises MOSI words into a parallel receive port, and serialises a buffered transmit word onto MISO. It operates in SPI mode 0 (CPOL=0, CPHA=0), MSB first. It is used in system benches and as a loop-back peer for the pipeline's SPI master.

## Interface
Parameters:
- WIDTH, 8, bits per SPI word
- FILL, 8'h00 (WIDTH bits), word sent on MISO when no transmit word is buffered

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- sclk  in  1  master serial clock (asynchronous to clk)
- ss  in  1  master slave-select, active low (asynchronous)
- mosi  in  1  master-out data (asynchronous)
- miso  out  1  slave-out data; 0 whenever ss (synchronised) is high
- tx_data  in  WIDTH  next word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmit buffer empty; write occurs when tx_valid & tx_ready
- rx_data  out  WIDTH  last complete received word; held until next word completes
- rx_valid  out  1  one-cycle pulse when rx_data updates
- busy  out  1  transfer in progress (synchronised ss low)
- tx_underrun  out  1  one-cycle pulse when FILL was loaded because buffer was empty

## Operation
- sclk, ss, mosi each pass through a 2-flop synchroniser; a third register on sclk and ss gives edge detection (rise = s2 & ~s3, fall = ~s2 & s3).
- Transmit buffer: one WIDTH register plus full flag. tx_ready = ~full. Write sets full; a load point clears it.
- FSM states: IDLE, SHIFT.
  - IDLE: busy=0, miso=0. On ss fall -> load point, bit_cnt=0, go SHIFT.
  - SHIFT: busy=1, miso = tx_shift[WIDTH-1].
    - sclk rise: rx_shift <= {rx_shift[WIDTH-2:0], mosi_s2}; bit_cnt++. When bit_cnt reaches WIDTH-1 on this edge: rx_data <= completed word, rx_valid pulse, bit_cnt wraps to 0.
    - sclk fall: if bit_cnt==0 (word boundary) -> load point; else tx_shift <= tx_shift << 1.
    - ss rise (any time): go IDLE; partial rx word discarded (no rx_valid); bit_cnt=0; tx buffer contents untouched.
- Load point: if full, tx_shift <= buffer, full cleared; else tx_shift <= FILL and tx_underrun pulses.
- Simultaneous buffer write and load point in same cycle: load sees buffer empty (FILL, underrun); the written word stays buffered for the next load point. No bypass.
- Back-to-back words with ss held low supported without gap.
- sclk edges while ss high are ignored.

## Timing
- Reset (rst=0 at clk edge): state IDLE, miso=0, busy=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, bit_cnt=0, shift registers 0, synchroniser flops 1 for ss, 0 for sclk/mosi. Reset mid-transfer aborts with no rx_valid.
- Input-to-action latency: 3 clk rising edges after a raw pin change (2 sync + edge register).
- rx_valid asserts 3 clk edges after the raw sclk rise of bit WIDTH-1; high exactly 1 cycle.
- miso changes 3 clk edges after raw ss fall (first bit) or raw sclk fall (subsequent bits).
- Requirement on master: each sclk half-period >= 4 clk periods; ss fall to first sclk rise >= 4 clk periods; mosi stable across the sampling window.
- tx_ready returns 1 one cycle after the load point consuming the buffer.

## Test plan
- Reset: hold rst=0 4 cycles with pins toggling -> miso=0, busy=0, tx_ready=1, rx_data=0, no pulses.
- Single word: write tx_data=8'hA5, master (sclk half-period 5 clk) sends 8'h3C -> master receives 8'hA5 on MISO, rx_data=8'h3C with one rx_valid pulse, tx_ready back to 1.
- Back-to-back: buffer 8'h11, then 8'h22 during word 1; master sends 8'h01,8'h02 with ss held low -> MISO 8'h11,8'h22; two rx_valid pulses with 8'h01 then 8'h02; no underrun.
- Underrun: no tx write, master sends 8'hFF -> MISO carries FILL (8'h00), tx_underrun pulses once at ss fall, rx_data=8'hFF.
- Abort: ss raised after 5 bits of 8'hC3 -> no rx_valid, busy drops 3 clk later, rx_data keeps previous value; next full transfer 8'h5A received correctly.
- Collision: tx_valid asserted in the exact load-point cycle -> FILL sent for that word, buffered word sent on the following word.
